interrupt_request_priority_service_8259: RTL and testbench

Holds interrupt state for the 8259A model. The block sits between the IR0–IR7 request pins and `Control_Logic_8259`, and contains three parts:
- the Interrupt Request Register (IRR), with edge or level capture;
- the priority resolver, with mask, special mask and rotation;
- the In-Service Register (ISR).

It supplies `interrupt` and `highest_level_in_service` to the control logic. It consumes the control logic's configuration, `freeze`, `latch_in_service`, `clear_interrupt_request` and `end_of_interrupt` outputs.

---
 rtl/interrupt_request_priority_service_8259_if.sv | 53 +++++
 rtl/interrupt_request_priority_service_8259.sv | 99 +++++++++
 tb/tb_interrupt_request_priority_service_8259.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_request_priority_service_8259_if.sv
// Bundle between the 8259 control logic and the request/priority/service block.
// The control side (master) drives configuration and strobes; the service
// block (slave) returns its registers and the resolved interrupt.
interface interrupt_request_priority_service_8259_if;
    logic [7:0] interrupt_request_pin;
    logic       level_or_edge_triggered_config;
    logic       special_fully_nest_config;
    logic       freeze;
    logic [7:0] clear_interrupt_request;
    logic [7:0] interrupt_mask;
    logic [7:0] interrupt_special_mask;
    logic [2:0] priority_rotate;
    logic       latch_in_service;
    logic [7:0] end_of_interrupt;
    logic [7:0] interrupt_request_register;
    logic [7:0] in_service_register;
    logic [7:0] interrupt;
    logic [7:0] highest_level_in_service;

    modport master (
        output interrupt_request_pin,
        output level_or_edge_triggered_config,
        output special_fully_nest_config,
        output freeze,
        output clear_interrupt_request,
        output interrupt_mask,
        output interrupt_special_mask,
        output priority_rotate,
        output latch_in_service,
        output end_of_interrupt,
        input  interrupt_request_register,
        input  in_service_register,
        input  interrupt,
        input  highest_level_in_service
    );

    modport slave (
        input  interrupt_request_pin,
        input  level_or_edge_triggered_config,
        input  special_fully_nest_config,
        input  freeze,
        input  clear_interrupt_request,
        input  interrupt_mask,
        input  interrupt_special_mask,
        input  priority_rotate,
        input  latch_in_service,
        input  end_of_interrupt,
        output interrupt_request_register,
        output in_service_register,
        output interrupt,
        output highest_level_in_service
    );
endinterface

// File: rtl/interrupt_request_priority_service_8259.sv
// 8259A interrupt request register, priority resolver and in-service register.
// Requests are captured from IR7..IR0 (edge or level), masked, resolved in a
// rotated priority order against the highest in-service level, and the
// winner is registered as a one-hot interrupt for the control logic.
module interrupt_request_priority_service_8259 (
    input  logic clock,
    input  logic reset,
    interrupt_request_priority_service_8259_if.slave bus
);

    logic [7:0] prev_pin;
    logic [7:0] irr;
    logic [7:0] irr_next;
    logic [7:0] isr;
    logic [7:0] int_reg;
    logic [7:0] int_next;
    logic [2:0] shift;
    logic [7:0] cand_rot;
    logic [7:0] hlis_rot;
    logic       win;

    // Rotate right so the highest-priority level lands at bit 0.
    function automatic logic [7:0] rot_r(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] d;
        d = {v, v} >> n;
        return d[7:0];
    endfunction

    // Inverse of rot_r: return a resolved vector to pin order.
    function automatic logic [7:0] rot_l(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // Isolate the lowest set bit, i.e. the highest priority after rotation.
    function automatic logic [7:0] lowest_one(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    // Next IRR value per bit: clear beats freeze beats pin capture.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        irr_next = irr;
        for (int i = 0; i < 8; i++) begin
            if (bus.clear_interrupt_request[i]) begin
                irr_next[i] = 1'b0;
            end else if (bus.freeze) begin
                irr_next[i] = irr[i];
            end else if (bus.level_or_edge_triggered_config) begin
                irr_next[i] = bus.interrupt_request_pin[i];
            end else if (bus.interrupt_request_pin[i] && !prev_pin[i]) begin
                irr_next[i] = 1'b1;
            end else if (!bus.interrupt_request_pin[i]) begin
                irr_next[i] = 1'b0;
            end
        end
    end

    // Priority resolution in rotated order: candidate request vs highest in-service level.
    always_comb begin
        shift    = bus.priority_rotate + 3'd1;
        cand_rot = lowest_one(rot_r(irr & ~bus.interrupt_mask, shift));
        hlis_rot = lowest_one(rot_r(isr & ~bus.interrupt_special_mask, shift));
        win      = 1'b0;
        if (cand_rot != 8'd0) begin
            // One-hot vectors: a smaller value means a higher priority.
            if (hlis_rot == 8'd0 || cand_rot < hlis_rot) begin
                win = 1'b1;
            end else if (bus.special_fully_nest_config && cand_rot == hlis_rot) begin
                win = 1'b1;
            end
        end
        int_next = win ? rot_l(cand_rot, shift) : 8'd0;
    end

    // Pin history, IRR, ISR and registered interrupt.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // All-ones so a line already high when reset releases is not seen as an edge.
            prev_pin <= 8'hFF;
            irr      <= 8'd0;
            isr      <= 8'd0;
            int_reg  <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            prev_pin <= bus.interrupt_request_pin;
            irr      <= irr_next;
            isr      <= (isr & ~bus.end_of_interrupt) | (bus.latch_in_service ? int_reg : 8'd0);
            int_reg  <= int_next;
        end
    end

    assign bus.interrupt_request_register = irr;
    assign bus.in_service_register        = isr;
    assign bus.interrupt                  = int_reg;
    assign bus.highest_level_in_service   = rot_l(hlis_rot, shift);

endmodule

// File: tb/tb_interrupt_request_priority_service_8259.sv
// Directed self-checking bench for the 8259 request/priority/service block.
module tb_interrupt_request_priority_service_8259;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    interrupt_request_priority_service_8259_if bus ();

    interrupt_request_priority_service_8259 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.interrupt_request_pin          = 8'h00;
        bus.level_or_edge_triggered_config = 1'b0;
        bus.special_fully_nest_config      = 1'b0;
        bus.freeze                         = 1'b0;
        bus.clear_interrupt_request        = 8'h00;
        bus.interrupt_mask                 = 8'h00;
        bus.interrupt_special_mask         = 8'h00;
        bus.priority_rotate                = 3'd7;
        bus.latch_in_service               = 1'b0;
        bus.end_of_interrupt               = 8'h00;
        #1;
        check("reset_irr", bus.interrupt_request_register, 8'h00);
        check("reset_isr", bus.in_service_register, 8'h00);
        check("reset_int", bus.interrupt, 8'h00);
        check("reset_hlis", bus.highest_level_in_service, 8'h00);
        tick();
        reset = 1'b0;
        tick();

        // 1. Edge capture and acknowledge
        bus.interrupt_request_pin = 8'h01;
        tick();
        check("edge_irr", bus.interrupt_request_register, 8'h01);
        check("edge_int_lat1", bus.interrupt, 8'h00);
        tick();
        check("edge_int_lat2", bus.interrupt, 8'h01);
        bus.latch_in_service        = 1'b1;
        bus.clear_interrupt_request = 8'h01;
        tick();
        bus.latch_in_service        = 1'b0;
        bus.clear_interrupt_request = 8'h00;
        check("ack_isr", bus.in_service_register, 8'h01);
        check("ack_irr", bus.interrupt_request_register, 8'h00);
        check("ack_hlis", bus.highest_level_in_service, 8'h01);
        tick();
        check("ack_int_drop", bus.interrupt, 8'h00);
        check("ack_no_reset", bus.interrupt_request_register, 8'h00);
        bus.end_of_interrupt = 8'h01;
        tick();
        bus.end_of_interrupt = 8'h00;
        bus.interrupt_request_pin = 8'h00;
        check("eoi_isr", bus.in_service_register, 8'h00);
        tick();

        // 2a. Nesting: put IR2 in service, then raise IR1 and IR3
        bus.interrupt_request_pin = 8'h04;
        tick();
        tick();
        bus.latch_in_service        = 1'b1;
        bus.clear_interrupt_request = 8'h04;
        tick();
        bus.latch_in_service        = 1'b0;
        bus.clear_interrupt_request = 8'h00;
        bus.interrupt_request_pin   = 8'h00;
        check("nest_isr", bus.in_service_register, 8'h04);
        tick();
        bus.interrupt_request_pin = 8'h0A;
        tick();
        check("nest_irr", bus.interrupt_request_register, 8'h0A);
        tick();
        check("nest_int", bus.interrupt, 8'h02);
        check("nest_hlis", bus.highest_level_in_service, 8'h04);
        bus.interrupt_mask = 8'h02;
        tick();
        check("nest_ir3_blocked", bus.interrupt, 8'h00);
        bus.interrupt_mask          = 8'h00;
        bus.end_of_interrupt        = 8'h04;
        bus.clear_interrupt_request = 8'h0A;
        bus.interrupt_request_pin   = 8'h00;
        tick();
        bus.end_of_interrupt        = 8'h00;
        bus.clear_interrupt_request = 8'h00;
        tick();
        check("nest_clean", bus.interrupt, 8'h00);

        // 2b. Special fully nested: same level re-wins only with SFNM
        bus.special_fully_nest_config = 1'b1;
        bus.interrupt_request_pin     = 8'h02;
        tick();
        tick();
        bus.latch_in_service = 1'b1;
        tick();
        bus.latch_in_service = 1'b0;
        check("sfnm_isr", bus.in_service_register, 8'h02);
        check("sfnm_irr", bus.interrupt_request_register, 8'h02);
        tick();
        check("sfnm_equal_wins", bus.interrupt, 8'h02);
        bus.special_fully_nest_config = 1'b0;
        tick();
        check("fnm_equal_loses", bus.interrupt, 8'h00);
        bus.end_of_interrupt        = 8'h02;
        bus.clear_interrupt_request = 8'h02;
        bus.interrupt_request_pin   = 8'h00;
        tick();
        bus.end_of_interrupt        = 8'h00;
        bus.clear_interrupt_request = 8'h00;
        tick();

        // 3. Rotation: rotate=2 makes IR3 highest
        bus.priority_rotate       = 3'd2;
        bus.interrupt_request_pin = 8'h09;
        tick();
        tick();
        check("rot2_int", bus.interrupt, 8'h08);
        bus.priority_rotate = 3'd7;
        tick();
        check("rot7_int", bus.interrupt, 8'h01);
        bus.clear_interrupt_request = 8'h09;
        bus.interrupt_request_pin   = 8'h00;
        tick();
        bus.clear_interrupt_request = 8'h00;
        tick();

        // 4a. Interrupt mask
        bus.interrupt_mask        = 8'h01;
        bus.interrupt_request_pin = 8'h03;
        tick();
        tick();
        check("mask_int", bus.interrupt, 8'h02);
        bus.clear_interrupt_request = 8'h03;
        bus.interrupt_request_pin   = 8'h00;
        bus.interrupt_mask          = 8'h00;
        tick();
        bus.clear_interrupt_request = 8'h00;
        tick();

        // 4b. Special mask hides IR0 in service so IR2 can win
        bus.interrupt_request_pin = 8'h01;
        tick();
        tick();
        bus.latch_in_service        = 1'b1;
        bus.clear_interrupt_request = 8'h01;
        tick();
        bus.latch_in_service        = 1'b0;
        bus.clear_interrupt_request = 8'h00;
        bus.interrupt_request_pin   = 8'h00;
        tick();
        bus.interrupt_request_pin = 8'h04;
        tick();
        tick();
        check("smask_off_int", bus.interrupt, 8'h00);
        bus.interrupt_special_mask = 8'h01;
        tick();
        check("smask_on_int", bus.interrupt, 8'h04);
        check("smask_hlis", bus.highest_level_in_service, 8'h00);
        bus.end_of_interrupt        = 8'h01;
        bus.clear_interrupt_request = 8'h04;
        bus.interrupt_special_mask  = 8'h00;
        bus.interrupt_request_pin   = 8'h00;
        tick();
        bus.end_of_interrupt        = 8'h00;
        bus.clear_interrupt_request = 8'h00;
        tick();

        // 5. Level mode, pin drop, freeze
        bus.level_or_edge_triggered_config = 1'b1;
        bus.interrupt_request_pin          = 8'h10;
        tick();
        check("level_irr", bus.interrupt_request_register, 8'h10);
        bus.freeze                = 1'b1;
        bus.interrupt_request_pin = 8'h00;
        tick();
        check("freeze_irr", bus.interrupt_request_register, 8'h10);
        bus.freeze = 1'b0;
        tick();
        check("level_drop_irr", bus.interrupt_request_register, 8'h00);
        bus.level_or_edge_triggered_config = 1'b0;

        // 5c. Edge mode: line held high across reset release is not an edge
        bus.interrupt_request_pin = 8'h20;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        check("held_reset_irr1", bus.interrupt_request_register, 8'h00);
        tick();
        check("held_reset_irr2", bus.interrupt_request_register, 8'h00);
        bus.interrupt_request_pin = 8'h00;
        tick();

        // 6. Async reset mid-service
        bus.interrupt_request_pin = 8'h80;
        tick();
        tick();
        bus.latch_in_service        = 1'b1;
        bus.clear_interrupt_request = 8'h80;
        tick();
        bus.latch_in_service        = 1'b0;
        bus.clear_interrupt_request = 8'h00;
        bus.interrupt_request_pin   = 8'h00;
        tick();
        bus.interrupt_request_pin = 8'h40;
        tick();
        tick();
        check("pre_rst_isr", bus.in_service_register, 8'h80);
        check("pre_rst_irr", bus.interrupt_request_register, 8'h40);
        check("pre_rst_int", bus.interrupt, 8'h40);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_irr", bus.interrupt_request_register, 8'h00);
        check("async_rst_isr", bus.in_service_register, 8'h00);
        check("async_rst_int", bus.interrupt, 8'h00);
        check("async_rst_hlis", bus.highest_level_in_service, 8'h00);
        tick();
        reset = 1'b0;
        bus.interrupt_request_pin = 8'h00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
